// File: rtl/sreg_load_ctrl_if.sv
// Handshake and shift-register drive bundle for sreg_load_ctrl.
//   master : upstream word source plus shift-register side (drives load_data/load_valid,
//            observes load_ready, sin, shift_en, latch, busy, done)
//   slave  : the controller itself
interface sreg_load_ctrl_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] load_data;
  logic         load_valid;
  logic         load_ready;
  logic         sin;
  logic         shift_en;
  logic         latch;
  logic         busy;
  logic         done;

  modport master (
    output load_data, load_valid,
    input  load_ready, sin, shift_en, latch, busy, done
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, sin, shift_en, latch, busy, done
  );
endinterface

// File: rtl/sreg_load_ctrl.sv
// Sequencer for the display-path serial-in shift register.
// Accepts a parallel word on a valid/ready handshake, shifts it out MSB-first on
// sin (one bit per shift_en strobe, each bit held for DIV clk cycles), then pulses
// latch/done so the downstream register updates atomically.
// Ports:
//   clk  - system clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - sreg_load_ctrl_if.slave: load_data/load_valid/load_ready handshake,
//          sin/shift_en/latch to the shift register, busy/done status
module sreg_load_ctrl #(
  parameter int unsigned N   = 4,
  parameter int unsigned DIV = 1
) (
  input logic             clk,
  input logic             rst,
  sreg_load_ctrl_if.slave bus
);

  if (DIV == 0) begin : g_div_check
    $error("sreg_load_ctrl: DIV must be >= 1");
  end

  localparam int unsigned BW = $clog2(N + 1);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t        state;
  logic [N-1:0]  shadow;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_inc;

  assign div_inc = div_cnt + DW'(1);

  // sin comes straight from the shadow MSB; it is zero in LATCH and after reset
  // because the shadow is then empty.
  assign bus.sin = shadow[N-1];

  // Strobe outputs are registered: each is loaded with the value it must have in
  // the state being entered, which keeps shift_en == (SHIFT && div_cnt == DIV-1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shadow         <= '0;
      bit_cnt        <= '0;
      div_cnt        <= '0;
      bus.load_ready <= 1'b1;
      bus.busy       <= 1'b0;
      bus.shift_en   <= 1'b0;
      bus.latch      <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            shadow         <= bus.load_data;
            bit_cnt        <= BW'(N);
            div_cnt        <= '0;
            state          <= SHIFT;
            bus.load_ready <= 1'b0;
            bus.busy       <= 1'b1;
            bus.shift_en   <= (DIV == 1);
          end
        end
        SHIFT: begin
          if (bus.shift_en) begin
            div_cnt <= '0;
            shadow  <= {shadow[N-2:0], 1'b0};
            bit_cnt <= bit_cnt - BW'(1);
            if (bit_cnt == BW'(1)) begin
              state        <= LATCH;
              bus.shift_en <= 1'b0;
              bus.latch    <= 1'b1;
              bus.done     <= 1'b1;
            end else begin
              bus.shift_en <= (DIV == 1);
            end
          end else begin
            div_cnt      <= div_inc;
            bus.shift_en <= (div_inc == DIV_LAST);
          end
        end
        LATCH: begin
          state          <= IDLE;
          bus.latch      <= 1'b0;
          bus.done       <= 1'b0;
          bus.busy       <= 1'b0;
          bus.load_ready <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          bus.shift_en   <= 1'b0;
          bus.latch      <= 1'b0;
          bus.done       <= 1'b0;
          bus.busy       <= 1'b0;
          bus.load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sreg_load_ctrl.sv
module tb_sreg_load_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  sreg_load_ctrl_if #(.N(4)) a_if ();
  sreg_load_ctrl_if #(.N(4)) b_if ();
  sreg_load_ctrl_if #(.N(8)) c_if ();

  sreg_load_ctrl #(.N(4), .DIV(1)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  sreg_load_ctrl #(.N(4), .DIV(3)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  sreg_load_ctrl #(.N(8), .DIV(1)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  // Downstream shift registers: shift in sin on the edge ending a shift_en cycle.
  logic [3:0] a_sr, b_sr;
  logic [7:0] c_sr;
  always @(posedge clk) begin
    if (a_if.shift_en) a_sr <= {a_sr[2:0], a_if.sin};
    if (b_if.shift_en) b_sr <= {b_sr[2:0], b_if.sin};
    if (c_if.shift_en) c_sr <= {c_sr[6:0], c_if.sin};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] w4;
  logic [7:0] w8;

  initial begin
    rst = 1'b1;
    a_if.load_valid = 1'b1; a_if.load_data = 4'hF;
    b_if.load_valid = 1'b0; b_if.load_data = '0;
    c_if.load_valid = 1'b0; c_if.load_data = '0;

    // Reset held two cycles with a word offered
    step();
    chk("rst1_busy", a_if.busy, 1'b0);
    chk("rst1_shift_en", a_if.shift_en, 1'b0);
    step();
    chk("rst2_busy", a_if.busy, 1'b0);
    chk("rst2_ready", a_if.load_ready, 1'b1);
    rst = 1'b0; a_if.load_valid = 1'b0;
    step();
    chk("rel_ready", a_if.load_ready, 1'b1);
    chk("rel_busy", a_if.busy, 1'b0);
    chk("rel_shift_en", a_if.shift_en, 1'b0);
    chk("rel_latch", a_if.latch, 1'b0);
    chk("rel_done", a_if.done, 1'b0);
    chk("rel_sin", a_if.sin, 1'b0);
    chk("rel_b_ready", b_if.load_ready, 1'b1);
    chk("rel_c_ready", c_if.load_ready, 1'b1);

    // N=4 DIV=1, word 1101
    w4 = 4'b1101;
    a_if.load_data = w4; a_if.load_valid = 1'b1;
    step();
    a_if.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("a1_shift_en", a_if.shift_en, 1'b1);
      chk("a1_sin", a_if.sin, w4[3-i]);
      chk("a1_busy", a_if.busy, 1'b1);
      chk("a1_ready", a_if.load_ready, 1'b0);
      chk("a1_latch_early", a_if.latch, 1'b0);
      step();
    end
    chk("a1_latch", a_if.latch, 1'b1);
    chk("a1_done", a_if.done, 1'b1);
    chk("a1_latch_shift_en", a_if.shift_en, 1'b0);
    chk("a1_latch_sin", a_if.sin, 1'b0);
    chk("a1_latch_busy", a_if.busy, 1'b1);
    chk("a1_out", a_sr, 4'b1101);
    step();
    chk("a1_ready_back", a_if.load_ready, 1'b1);
    chk("a1_latch_off", a_if.latch, 1'b0);
    chk("a1_busy_off", a_if.busy, 1'b0);

    // N=4 DIV=3, word 0110
    w4 = 4'b0110;
    b_if.load_data = w4; b_if.load_valid = 1'b1;
    step();
    b_if.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        chk("b_sin", b_if.sin, w4[3-i]);
        chk("b_shift_en", b_if.shift_en, (k == 2));
        chk("b_busy", b_if.busy, 1'b1);
        step();
      end
    end
    chk("b_latch", b_if.latch, 1'b1);
    chk("b_done", b_if.done, 1'b1);
    chk("b_out", b_sr, 4'b0110);
    step();
    chk("b_ready_back", b_if.load_ready, 1'b1);

    // Back-to-back with load_valid held: A then 5, mid-SHIFT change to F ignored
    a_if.load_data = 4'hA; a_if.load_valid = 1'b1;
    step();
    a_if.load_data = 4'hF;
    w4 = 4'hA;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) a_if.load_data = 4'h5;
      chk("bb1_shift_en", a_if.shift_en, 1'b1);
      chk("bb1_sin", a_if.sin, w4[3-i]);
      step();
    end
    chk("bb1_latch", a_if.latch, 1'b1);
    chk("bb1_out", a_sr, 4'hA);
    step();
    chk("bb_gap_ready", a_if.load_ready, 1'b1);
    chk("bb_gap_busy", a_if.busy, 1'b0);
    step();
    a_if.load_valid = 1'b0;
    chk("bb2_ready", a_if.load_ready, 1'b0);
    w4 = 4'h5;
    for (int i = 0; i < 4; i++) begin
      chk("bb2_shift_en", a_if.shift_en, 1'b1);
      chk("bb2_sin", a_if.sin, w4[3-i]);
      step();
    end
    chk("bb2_latch", a_if.latch, 1'b1);
    chk("bb2_out", a_sr, 4'h5);
    step();

    // Reset after 2nd strobe of 1011: abandoned, then 0001 completes
    a_if.load_data = 4'b1011; a_if.load_valid = 1'b1;
    step();
    a_if.load_valid = 1'b0;
    chk("ab_s1_sin", a_if.sin, 1'b1);
    step();
    chk("ab_s2_sin", a_if.sin, 1'b0);
    chk("ab_s2_shift_en", a_if.shift_en, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_latch", a_if.latch, 1'b0);
    chk("ab_done", a_if.done, 1'b0);
    chk("ab_ready", a_if.load_ready, 1'b1);
    chk("ab_busy", a_if.busy, 1'b0);
    chk("ab_sin", a_if.sin, 1'b0);
    step();
    chk("ab_latch2", a_if.latch, 1'b0);
    w4 = 4'b0001;
    a_if.load_data = w4; a_if.load_valid = 1'b1;
    step();
    a_if.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ab_new_shift_en", a_if.shift_en, 1'b1);
      chk("ab_new_sin", a_if.sin, w4[3-i]);
      step();
    end
    chk("ab_new_latch", a_if.latch, 1'b1);
    chk("ab_new_out", a_sr, 4'b0001);
    step();

    // N=8 DIV=1, word 81
    w8 = 8'h81;
    c_if.load_data = w8; c_if.load_valid = 1'b1;
    step();
    c_if.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("c_shift_en", c_if.shift_en, 1'b1);
      chk("c_sin", c_if.sin, w8[7-i]);
      chk("c_latch_early", c_if.latch, 1'b0);
      step();
    end
    chk("c_latch", c_if.latch, 1'b1);
    chk("c_done", c_if.done, 1'b1);
    chk("c_out", c_sr, 8'h81);
    step();
    chk("c_ready_back", c_if.load_ready, 1'b1);
    chk("c_busy_off", c_if.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sreg_load_ctrl.md
Name: sreg_load_ctrl

Overview:
Sequencer for the serial-in shift register (clk/rst/sin, n-bit parallel out) used in the digital clock display path. It accepts a parallel word through a valid/ready handshake and shifts it into the register MSB-first, one bit per shift strobe. It then pulses a latch strobe so the downstream digit/segment register updates atomically. It replaces hand-driven sin sequencing, so that upstream logic only presents words.

Parameters:
N, 4, shift register width in bits (>=2); must match the driven shift register's n.
DIV, 1, clk cycles per shifted bit (>=1); DIV=0 is illegal and rejected by an elaboration-time check.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset, sampled on posedge clk.
load_data  input  N  parallel word to shift out; sampled on the handshake cycle only.
load_valid  input  1  upstream has a word.
load_ready  output  1  controller can accept a word (high only in IDLE).
sin  output  1  serial data to shift register; equals shadow[N-1].
shift_en  output  1  one-cycle strobe; shift register must shift on the posedge ending this cycle.
latch  output  1  one-cycle strobe after the last bit; downstream captures parallel out.
busy  output  1  high in SHIFT and LATCH.
done  output  1  one-cycle pulse, coincident with latch.

Behaviour:
- Internal state: FSM {IDLE, SHIFT, LATCH}; shadow[N-1:0]; bit_cnt (clog2(N+1) bits); div_cnt (max(1,clog2(DIV)) bits).
- Reset (rst=1 at posedge): state=IDLE, shadow=0, bit_cnt=0, div_cnt=0. Next cycle: load_ready=1, sin=0, shift_en=0, latch=0, busy=0, done=0. Reset overrides everything, including mid-SHIFT or LATCH. The partial transfer is abandoned and no latch is issued.
- IDLE: load_ready=1, busy=0, sin=shadow[N-1]. On posedge with load_valid=1: shadow<=load_data, bit_cnt<=N, div_cnt<=0, go SHIFT. With load_valid=0: stay.
- SHIFT: load_ready=0, busy=1, sin=shadow[N-1]. shift_en=(div_cnt==DIV-1), combinational from registered state.
  - On posedge with shift_en=0: div_cnt++.
  - On posedge with shift_en=1: div_cnt<=0, shadow<=shadow<<1 (LSB filled with 0), bit_cnt--. If bit_cnt==1, go LATCH.
  - sin is stable for the whole DIV-cycle bit period, including the strobe cycle.
- LATCH: latch=1, done=1, busy=1, shift_en=0, load_ready=0, sin=0 (shadow is fully shifted). Unconditionally go IDLE next posedge.
- Latency with DIV=1: the handshake at edge E0 gives shift_en high in cycles 1..N, latch in cycle N+1, load_ready in cycle N+2. In general, a transaction occupies N*DIV+1 cycles after the handshake edge, then IDLE.
- Back-to-back words: at least one IDLE cycle between transfers (load_ready is only high in IDLE). load_valid held high is accepted on the first IDLE posedge.
- load_valid or load_data changes while busy are ignored; the captured word is unaffected.
- Bit order: load_data[N-1] is the first bit presented on sin. After N shifts, the shift register's out equals load_data when out is ordered {first bit...last bit} = {out[N-1]..out[0]}.
- All outputs are functions of registered state only; no input-to-output combinational paths.

Test Plan:
- Reset: hold rst=1 for 2 cycles, mid-stream load_valid=1 -> after release load_ready=1, busy=0, shift_en=0, latch=0, sin=0; no word accepted while rst=1.
- N=4, DIV=1, load 4'b1101 -> sin=1,1,0,1 on the four consecutive shift_en cycles; latch+done on cycle 5; bench shift-register model out=4'b1101 at latch; load_ready back on cycle 6.
- N=4, DIV=3, load 4'b0110 -> shift_en every 3rd cycle (4 strobes total), sin held constant for each 3-cycle bit period, latch on cycle 13, model out=4'b0110.
- load_valid held high with data 4'hA then 4'h5 -> two transfers separated by exactly one IDLE cycle; latched values 4'hA then 4'h5. A data change to 4'hF mid-SHIFT has no effect.
- rst asserted after the 2nd shift_en of 4'b1011 -> no latch pulse; IDLE the next cycle; a new load of 4'b0001 completes correctly with out=4'b0001.
- N=8, DIV=1, load 8'h81 -> 8 strobes, sin=1,0,0,0,0,0,0,1, latch on cycle 9.
